// File: rtl/memoria_arbiter.sv
// Two-client req/ack arbiter in front of the MemoriaDeco write port and read port A.
// Optional feature: define MEMARB_FIXED_PRIO_EN to give client 0 fixed priority on ties.
//
// state   | meaning
// IDLE    | waiting for a request; grant and latch winner fields
// WRITE   | memwrite pulse for one cycle
// READ    | memread held READ_LAT cycles; read data captured on the last one
// DONE    | ack to winner, response valid, counter bump, rr_ptr update
module memoria_arbiter #(
    parameter int NREGS    = 32,
    parameter int READ_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             c0_req,
    input  logic             c0_wr,
    input  logic [31:0]      c0_addr,
    input  logic [31:0]      c0_wdata,
    output logic             c0_ack,
    input  logic             c1_req,
    input  logic             c1_wr,
    input  logic [31:0]      c1_addr,
    input  logic [31:0]      c1_wdata,
    output logic             c1_ack,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] served_cnt,
    output logic [31:0]      mem_addrA,
    output logic [31:0]      mem_addrWR,
    output logic [31:0]      mem_write_data,
    output logic             mem_memwrite,
    output logic             mem_memread,
    input  logic [31:0]      mem_read_dataA
);

    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

    state_t             state, state_d;
    logic               id_q;
    logic               err_q;
    logic               rr_ptr;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic [LAT_W-1:0]   lat_cnt;

    logic               pick;
    logic               sel_wr;
    logic [31:0]        sel_addr;
    logic [31:0]        sel_wdata;
    logic               sel_err;

    always_comb begin
        pick = 1'b0;
`ifdef MEMARB_FIXED_PRIO_EN
        pick = ~c0_req;
`else
        if (c0_req && c1_req)
            pick = rr_ptr;
        else
            pick = c1_req;
`endif
        sel_wr    = pick ? c1_wr    : c0_wr;
        sel_addr  = pick ? c1_addr  : c0_addr;
        sel_wdata = pick ? c1_wdata : c0_wdata;
        sel_err   = (sel_addr >= 32'(NREGS));
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (c0_req || c1_req) begin
                    if (sel_err)
                        state_d = S_DONE;
                    else if (sel_wr)
                        state_d = S_WRITE;
                    else
                        state_d = S_READ;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_READ:  if (lat_cnt == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            id_q       <= 1'b0;
            err_q      <= 1'b0;
            rr_ptr     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            lat_cnt    <= '0;
            served_cnt <= '0;
        end else begin
            state <= state_d;
            case (state)
                S_IDLE: begin
                    if (c0_req || c1_req) begin
                        id_q    <= pick;
                        err_q   <= sel_err;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        rdata_q <= '0;
                        lat_cnt <= LAT_W'(READ_LAT - 1);
                    end
                end
                S_READ: begin
                    if (lat_cnt == '0)
                        rdata_q <= mem_read_dataA;
                    else
                        lat_cnt <= lat_cnt - 1'b1;
                end
                S_DONE: begin
                    if (served_cnt != '1)
                        served_cnt <= served_cnt + 1'b1;
`ifdef MEMARB_FIXED_PRIO_EN
                    rr_ptr <= 1'b0;
`else
                    rr_ptr <= ~id_q;
`endif
                end
                default: ;
            endcase
        end
    end

    // Strobes and acks decode straight from state so an async reset kills them at once.
    assign mem_memwrite   = (state == S_WRITE);
    assign mem_memread    = (state == S_READ);
    assign busy           = (state != S_IDLE);
    assign c0_ack         = (state == S_DONE) && !id_q;
    assign c1_ack         = (state == S_DONE) &&  id_q;
    assign rsp_err        = (state == S_DONE) && err_q;
    assign rsp_rdata      = rdata_q;
    assign mem_addrA      = addr_q;
    assign mem_addrWR     = addr_q;
    assign mem_write_data = wdata_q;

endmodule
